// File: rtl/mips_cpu_avalon_arbiter_if.sv
// Bus bundle between the MIPS CPU ports, the arbiter and the unified Avalon RAM.
// master = CPU/memory environment view, slave = arbiter view.
interface mips_cpu_avalon_arbiter_if;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_waitrequest;
  logic [31:0] i_readdata;

  logic [31:0] d_address;
  logic        d_read;
  logic        d_write;
  logic [3:0]  d_byteenable;
  logic [31:0] d_writedata;
  logic        d_waitrequest;
  logic [31:0] d_readdata;

  logic [31:0] s_address;
  logic        s_read;
  logic        s_write;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic [31:0] s_readdata;

  modport master (
    output i_address, i_read,
    input  i_waitrequest, i_readdata,
    output d_address, d_read, d_write, d_byteenable, d_writedata,
    input  d_waitrequest, d_readdata,
    input  s_address, s_read, s_write, s_byteenable, s_writedata,
    output s_waitrequest, s_readdata
  );

  modport slave (
    input  i_address, i_read,
    output i_waitrequest, i_readdata,
    input  d_address, d_read, d_write, d_byteenable, d_writedata,
    output d_waitrequest, d_readdata,
    output s_address, s_read, s_write, s_byteenable, s_writedata,
    input  s_waitrequest, s_readdata
  );
endinterface

// File: rtl/mips_cpu_avalon_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM RAM port between the MIPS
// instruction-fetch and data ports, with an optional completion watchdog.
module mips_cpu_avalon_arbiter #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic                            clk,
  input  logic                            reset_n,
  mips_cpu_avalon_arbiter_if.slave        bus,
  output logic                            timeout_err
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              WDOG_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
  typedef enum logic       {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;

  state_t           r_state,  w_state;
  gnt_t             r_grant,  w_grant;
  gnt_t             r_last,   w_last;
  logic [31:0]      r_addr,   w_addr;
  logic [3:0]       r_be,     w_be;
  logic [31:0]      r_wd,     w_wd;
  logic             r_rd,     w_rd;
  logic             r_wr,     w_wr;
  logic [31:0]      r_rdata,  w_rdata;
  logic [CNT_W-1:0] r_cnt,    w_cnt;
  logic             r_terr,   w_terr;
  logic             r_i_wait, w_i_wait;
  logic             r_d_wait, w_d_wait;
  logic             w_i_req, w_d_req, w_pick_d, w_done;

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= GNT_I;
      r_last   <= GNT_D;
      r_addr   <= '0;
      r_be     <= '0;
      r_wd     <= '0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_rdata  <= '0;
      r_cnt    <= '0;
      r_terr   <= 1'b0;
      r_i_wait <= 1'b1;
      r_d_wait <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_grant  <= w_grant;
      r_last   <= w_last;
      r_addr   <= w_addr;
      r_be     <= w_be;
      r_wd     <= w_wd;
      r_rd     <= w_rd;
      r_wr     <= w_wr;
      r_rdata  <= w_rdata;
      r_cnt    <= w_cnt;
      r_terr   <= w_terr;
      r_i_wait <= w_i_wait;
      r_d_wait <= w_d_wait;
    end
  end

  // Next-state, arbitration and command sequencing
  always_comb begin
    w_state  = r_state;
    w_grant  = r_grant;
    w_last   = r_last;
    w_addr   = r_addr;
    w_be     = r_be;
    w_wd     = r_wd;
    w_rd     = r_rd;
    w_wr     = r_wr;
    w_rdata  = r_rdata;
    w_cnt    = r_cnt;
    w_terr   = r_terr;
    w_i_wait = 1'b1;
    w_d_wait = 1'b1;
    w_i_req  = bus.i_read;
    w_d_req  = bus.d_read | bus.d_write;
    w_pick_d = 1'b0;
    w_done   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_i_req || w_d_req) begin
          // On a tie the port that did not win last time goes first
          w_pick_d = w_d_req && !(w_i_req && (r_last == GNT_D));
          if (w_pick_d) begin
            w_addr  = bus.d_address;
            w_be    = bus.d_byteenable;
            w_wd    = bus.d_writedata;
            w_rd    = bus.d_read;
            w_wr    = bus.d_write & ~bus.d_read;
            w_grant = GNT_D;
          end else begin
            w_addr  = bus.i_address;
            w_be    = 4'hF;
            w_wd    = '0;
            w_rd    = 1'b1;
            w_wr    = 1'b0;
            w_grant = GNT_I;
          end
          w_last  = w_grant;
          w_cnt   = '0;
          w_state = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!bus.s_waitrequest) begin
          if (r_rd) w_rdata = bus.s_readdata;
          w_done = 1'b1;
        end else if (WDOG_EN && (r_cnt == CNT_LAST)) begin
          w_rdata = '0;
          w_terr  = 1'b1;
          w_done  = 1'b1;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_RESP: w_state = ST_IDLE;
      default: w_state = ST_IDLE;
    endcase

    if (w_done) begin
      w_rd     = 1'b0;
      w_wr     = 1'b0;
      w_state  = ST_RESP;
      w_i_wait = (r_grant != GNT_I);
      w_d_wait = (r_grant != GNT_D);
    end
  end

  assign bus.s_address     = r_addr;
  assign bus.s_read        = r_rd;
  assign bus.s_write       = r_wr;
  assign bus.s_byteenable  = r_be;
  assign bus.s_writedata   = r_wd;
  assign bus.i_waitrequest = r_i_wait;
  assign bus.d_waitrequest = r_d_wait;
  assign bus.i_readdata    = r_rdata;
  assign bus.d_readdata    = r_rdata;
  assign timeout_err       = r_terr;

endmodule

// File: tb/tb_mips_cpu_avalon_arbiter.sv
// Bench for mips_cpu_avalon_arbiter: directed scenarios plus random two-master
// traffic against a RAM slave, checked every cycle by a transaction-level model.
module tb_mips_cpu_avalon_arbiter;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic reset_n;
  logic timeout_err;

  mips_cpu_avalon_arbiter_if bus ();

  mips_cpu_avalon_arbiter #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int s_rd_hi = 0;
  int d_wlo   = 0;
  int done_q[$];
  bit never = 1'b0;
  bit rand_wait = 1'b0;
  int slave_wait = 0;

  logic [31:0] smem [logic [29:0]];
  logic [31:0] rmem [logic [29:0]];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a[31:2] == 30'h2FF00000) return 32'h3C011234;
    if (a[31:2] == 30'h2FF00004) return 32'h11223344;
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return smem.exists(a[31:2]) ? smem[a[31:2]] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return rmem.exists(a[31:2]) ? rmem[a[31:2]] : init_word(a);
  endfunction

  // RAM slave: programmable wait states, writes commit on acceptance
  initial begin
    logic pcmd, acc;
    logic [31:0] wa, wdv;
    logic [3:0] wbe;
    int sw_cnt, cur_wait;
    bus.s_waitrequest = 1'b1;
    bus.s_readdata    = '0;
    sw_cnt = 0;
    cur_wait = 0;
    forever begin
      @(negedge clk);
      pcmd = bus.s_read || bus.s_write;
      acc  = bus.s_write && !bus.s_waitrequest;
      wa = bus.s_address; wdv = bus.s_writedata; wbe = bus.s_byteenable;
      @(posedge clk);
      #2;
      if (acc) smem[wa[31:2]] = merge(slave_rd(wa), wdv, wbe);
      if (pcmd) sw_cnt++;
      else begin
        sw_cnt = 0;
        cur_wait = rand_wait ? int'($urandom_range(0, 3)) : slave_wait;
      end
      bus.s_waitrequest = never || !((bus.s_read || bus.s_write) && sw_cnt >= cur_wait);
      bus.s_readdata    = slave_rd(bus.s_address);
    end
  end

  // Reference model: who owns the slave, what command it carries, what each master sees
  int          m_phase;   // 0 free, 1 command outstanding, 2 response cycle
  int          m_busy;
  bit          m_last_d, m_gnt_d, m_rd, m_wr, m_fin;
  logic        e_rd, e_wr, e_iw, e_dw, m_terr;
  logic [31:0] e_addr, e_wd, m_rdata;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    if (!reset_n) begin
      m_phase = 0; m_busy = 0; m_last_d = 1'b1; m_gnt_d = 1'b0; m_rd = 1'b0; m_wr = 1'b0;
      e_rd = 1'b0; e_wr = 1'b0; e_iw = 1'b1; e_dw = 1'b1; m_terr = 1'b0;
      e_addr = '0; e_wd = '0; e_be = '0; m_rdata = '0;
    end else begin
      chk("s_read", 32'(bus.s_read), 32'(e_rd));
      chk("s_write", 32'(bus.s_write), 32'(e_wr));
      chk("i_waitrequest", 32'(bus.i_waitrequest), 32'(e_iw));
      chk("d_waitrequest", 32'(bus.d_waitrequest), 32'(e_dw));
      chk("i_readdata", bus.i_readdata, m_rdata);
      chk("d_readdata", bus.d_readdata, m_rdata);
      chk("timeout_err", 32'(timeout_err), 32'(m_terr));
      if (e_rd || e_wr) begin
        chk("s_address", bus.s_address, e_addr);
        chk("s_byteenable", 32'(bus.s_byteenable), 32'(e_be));
      end
      if (e_wr) chk("s_writedata", bus.s_writedata, e_wd);
      if (bus.s_read) s_rd_hi++;
      if (!bus.d_waitrequest) d_wlo++;

      m_fin = 1'b0;
      e_iw = 1'b1;
      e_dw = 1'b1;
      if (m_phase == 0) begin
        if (bus.i_read || bus.d_read || bus.d_write) begin
          if (bus.i_read && (bus.d_read || bus.d_write)) m_gnt_d = !m_last_d;
          else m_gnt_d = bus.d_read || bus.d_write;
          m_last_d = m_gnt_d;
          if (m_gnt_d) begin
            m_rd = bus.d_read; m_wr = bus.d_write && !bus.d_read;
            e_addr = bus.d_address; e_be = bus.d_byteenable; e_wd = bus.d_writedata;
          end else begin
            m_rd = 1'b1; m_wr = 1'b0; e_addr = bus.i_address; e_be = 4'hF;
          end
          e_rd = m_rd; e_wr = m_wr; m_busy = 0; m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_busy++;
        if (!bus.s_waitrequest) begin
          if (m_rd) m_rdata = ref_rd(e_addr);
          else rmem[e_addr[31:2]] = merge(ref_rd(e_addr), e_wd, e_be);
          m_fin = 1'b1;
        end else if (m_busy == int'(TO)) begin
          m_rdata = '0; m_terr = 1'b1; m_fin = 1'b1;
        end
        if (m_fin) begin
          e_rd = 1'b0; e_wr = 1'b0; e_iw = m_gnt_d; e_dw = !m_gnt_d; m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  task automatic i_txn(input logic [31:0] a, output logic [31:0] data, output int cyc);
    @(posedge clk); #1;
    bus.i_address = a; bus.i_read = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.i_waitrequest && cyc < 64);
    if (bus.i_waitrequest) begin
      n_tests++; n_fail++;
      $display("FAIL i_handshake: waitrequest still 1 after %0d cycles, required 0", cyc);
    end
    data = bus.i_readdata;
    done_q.push_back(0);
    @(posedge clk); #1;
    bus.i_read = 1'b0;
  endtask

  task automatic d_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] data, output int cyc);
    @(posedge clk); #1;
    bus.d_address = a; bus.d_read = rd; bus.d_write = wr; bus.d_byteenable = be; bus.d_writedata = wd;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (bus.d_waitrequest && cyc < 64);
    if (bus.d_waitrequest) begin
      n_tests++; n_fail++;
      $display("FAIL d_handshake: waitrequest still 1 after %0d cycles, required 0", cyc);
    end
    data = bus.d_readdata;
    done_q.push_back(1);
    @(posedge clk); #1;
    bus.d_read = 1'b0; bus.d_write = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] rd;
    int cyc;
    reset_n = 1'b0;
    bus.i_address = '0; bus.i_read = 1'b0;
    bus.d_address = '0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    bus.d_byteenable = '0; bus.d_writedata = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_s_address", bus.s_address, 32'h0);
    chk("rst_s_read", 32'(bus.s_read), 32'h0);
    chk("rst_i_wait", 32'(bus.i_waitrequest), 32'h1);
    chk("rst_d_wait", 32'(bus.d_waitrequest), 32'h1);
    chk("rst_timeout_err", 32'(timeout_err), 32'h0);

    // Single instruction read, zero-wait slave
    s_rd_hi = 0; d_wlo = 0;
    i_txn(32'hBFC00000, rd, cyc);
    chk("ifetch_cycles", 32'(cyc), 32'd3);
    chk("ifetch_data", rd, 32'h3C011234);
    chk("ifetch_s_read_cycles", 32'(s_rd_hi), 32'd1);
    chk("ifetch_d_wait_low", 32'(d_wlo), 32'd0);

    // Partial-byte write then read-back
    d_txn(1'b0, 1'b1, 32'hBFC00010, 4'b0011, 32'hAABBCCDD, rd, cyc);
    chk("pwrite_cycles", 32'(cyc), 32'd3);
    d_txn(1'b1, 1'b0, 32'hBFC00010, 4'b1111, 32'h0, rd, cyc);
    chk("pwrite_readback", rd, 32'h1122CCDD);

    // Simultaneous requests straight out of reset alternate I, D, I, D
    reset_pulse();
    done_q.delete();
    fork
      begin logic [31:0] x; int c; i_txn(32'hBFC00000, x, c); i_txn(32'hBFC00000, x, c); end
      begin logic [31:0] x; int c;
        d_txn(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, x, c);
        d_txn(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, x, c);
      end
    join
    chk("rr_count", 32'(done_q.size()), 32'd4);
    if (done_q.size() == 4) begin
      chk("rr_order0", 32'(done_q[0]), 32'd0);
      chk("rr_order1", 32'(done_q[1]), 32'd1);
      chk("rr_order2", 32'(done_q[2]), 32'd0);
      chk("rr_order3", 32'(done_q[3]), 32'd1);
    end

    // Five slave wait states
    slave_wait = 5;
    d_txn(1'b1, 1'b0, 32'hBFC00010, 4'hF, 32'h0, rd, cyc);
    slave_wait = 0;
    chk("wait5_cycles", 32'(cyc), 32'd8);
    chk("wait5_data", rd, 32'h1122CCDD);

    // Watchdog abort after 8 BUSY cycles, flag is sticky
    never = 1'b1; s_rd_hi = 0;
    i_txn(32'hBFC00000, rd, cyc);
    never = 1'b0;
    chk("wdog_cycles", 32'(cyc), 32'd10);
    chk("wdog_data", rd, 32'h0);
    chk("wdog_s_read_cycles", 32'(s_rd_hi), 32'd8);
    chk("wdog_flag", 32'(timeout_err), 32'h1);
    i_txn(32'hBFC00000, rd, cyc);
    chk("wdog_after_data", rd, 32'h3C011234);
    chk("wdog_flag_sticky", 32'(timeout_err), 32'h1);

    // Reset while BUSY takes effect without a clock edge
    never = 1'b1;
    @(posedge clk); #1;
    bus.d_address = 32'hBFC00000; bus.d_read = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rbusy_s_read", 32'(bus.s_read), 32'h0);
    chk("rbusy_i_wait", 32'(bus.i_waitrequest), 32'h1);
    chk("rbusy_d_wait", 32'(bus.d_waitrequest), 32'h1);
    chk("rbusy_timeout_err", 32'(timeout_err), 32'h0);
    bus.d_read = 1'b0;
    never = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    i_txn(32'hBFC00000, rd, cyc);
    chk("rbusy_after_cycles", 32'(cyc), 32'd3);
    chk("rbusy_after_data", rd, 32'h3C011234);

    // Random two-master traffic with random slave wait states
    rand_wait = 1'b1;
    fork
      begin logic [31:0] x; int c;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          i_txn(32'hBFC00000 + (32'($urandom_range(0, 7)) << 2), x, c);
        end
      end
      begin logic [31:0] x; int c; int op;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          op = int'($urandom_range(0, 3));
          d_txn(op == 0 || op == 3, op != 0, 32'hBFC00000 + (32'($urandom_range(0, 7)) << 2),
                4'($urandom_range(0, 15)), $urandom, x, c);
        end
      end
    join
    rand_wait = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
